// File: rtl/rf_pkg.sv
// rf_pkg: shared constants and types for the register-file access controller.
//   DATA_W / ADDR_W / NUM_REGS : register file geometry (32 x 16)
//   wb_entry_t                 : queued writeback {addr, data}
//   rf_op_e                    : port operation chosen for the current cycle
package rf_pkg;
  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 1 << ADDR_W;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  typedef enum logic [1:0] {RF_IDLE, RF_READ, RF_WRITE} rf_op_e;
endpackage

// File: rtl/rf_wb_queue.sv
// rf_wb_queue: circular FIFO of pending writebacks with a two-port
// youngest-match search used for read forwarding.
//   clk, rst         : clock, async active-high reset
//   i_push/i_push_entry : enqueue (ignored when full unless popping)
//   i_pop            : dequeue head (ignored when empty)
//   o_head           : oldest entry
//   o_full/o_empty/o_count : occupancy
//   i_srch_addr[p]   : search address for port p
//   o_srch_hit/data  : youngest matching entry, the incoming push included
module rf_wb_queue import rf_pkg::*; #(
  parameter  int WB_DEPTH = 4,
  localparam int PTR_W    = $clog2(WB_DEPTH),
  localparam int CNT_W    = PTR_W + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  wb_entry_t              i_push_entry,
  input  logic                   i_pop,
  output wb_entry_t              o_head,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [CNT_W-1:0]       o_count,
  input  logic [1:0][ADDR_W-1:0] i_srch_addr,
  output logic [1:0]             o_srch_hit,
  output logic [1:0][DATA_W-1:0] o_srch_data
);
  wb_entry_t        r_mem [WB_DEPTH];
  logic [PTR_W-1:0] r_rd_ptr, r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push, w_pop;
  logic [PTR_W-1:0] w_idx;

  assign o_full  = (r_count == CNT_W'(WB_DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

  // A pop in the same cycle frees the slot a full-queue push needs.
  assign w_pop  = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_entry;
  end

  // Walk oldest to youngest so later matches overwrite earlier ones; the
  // incoming push is younger than everything stored.
  always_comb begin
    o_srch_hit  = '0;
    o_srch_data = '0;
    w_idx       = '0;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < WB_DEPTH; i++) begin
        w_idx = r_rd_ptr + PTR_W'(i);
        if ((CNT_W'(i) < r_count) && (r_mem[w_idx].addr == i_srch_addr[p])) begin
          o_srch_hit[p]  = 1'b1;
          o_srch_data[p] = r_mem[w_idx].data;
        end
      end
      if (w_push && (i_push_entry.addr == i_srch_addr[p])) begin
        o_srch_hit[p]  = 1'b1;
        o_srch_data[p] = i_push_entry.data;
      end
    end
  end
endmodule

// File: rtl/rf_access_ctrl.sv
// rf_access_ctrl: initiator side of a single-ported 32x16 register file.
// Arbitrates operand reads against buffered writebacks, returns read data
// one cycle after issue and forwards from writes not yet committed.
//   clk, rst                      : clock, async active-high reset
//   rd_valid/rd_ready/rd_addr_a/b : operand-read request
//   rd_data_valid/rd_data_a/b     : read result, exactly one cycle after issue
//   wb_valid/wb_ready/wb_addr/data: writeback request (queued)
//   rf_regA/B/C, rf_dado, rf_RW   : register file drive (RW 0=read 1=write)
//   rf_saidaA/B                   : register file read data (registered)
//   wb_empty                      : no uncommitted writes
// Optional: define RF_R0_ZERO_EN to hardwire register 0 to zero.
module rf_access_ctrl import rf_pkg::*; #(
  parameter int DATA_W   = rf_pkg::DATA_W,
  parameter int ADDR_W   = rf_pkg::ADDR_W,
  parameter int WB_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic              rd_data_valid,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic [ADDR_W-1:0] rf_regA,
  output logic [ADDR_W-1:0] rf_regB,
  output logic [ADDR_W-1:0] rf_regC,
  output logic [DATA_W-1:0] rf_dado,
  output logic              rf_RW,
  input  logic [DATA_W-1:0] rf_saidaA,
  input  logic [DATA_W-1:0] rf_saidaB,
  output logic              wb_empty
);
  localparam int CNT_W = $clog2(WB_DEPTH) + 1;

  rf_op_e                   w_op;
  logic                     w_full, w_empty;
  logic [CNT_W-1:0]         w_count;
  wb_entry_t                w_head, w_push_entry;
  logic                     w_rd_acc, w_wb_acc, w_q_push;
  logic [1:0][ADDR_W-1:0]   w_rd_addr;
  logic [1:0]               w_srch_hit;
  logic [1:0][DATA_W-1:0]   w_srch_data;

  logic                     r_rd_vld;
  logic [1:0]               r_fwd_hit;
  logic [1:0][DATA_W-1:0]   r_fwd_data;

  assign w_rd_addr    = {rd_addr_b, rd_addr_a};
  assign w_push_entry = '{addr: wb_addr, data: wb_data};

  // Full queue wins the port so a writeback can always be accepted.
  always_comb begin
    if (w_full)        w_op = RF_WRITE;
    else if (rd_valid) w_op = RF_READ;
    else if (!w_empty) w_op = RF_WRITE;
    else               w_op = RF_IDLE;
  end

  assign rd_ready = !w_full;
  assign wb_ready = !w_full || (w_op == RF_WRITE);
  assign w_rd_acc = rd_valid && rd_ready;
  assign w_wb_acc = wb_valid && wb_ready;
  assign wb_empty = w_empty;

`ifdef RF_R0_ZERO_EN
  // Writes to r0 are acknowledged and dropped.
  assign w_q_push = w_wb_acc && (wb_addr != '0);
`else
  assign w_q_push = w_wb_acc;
`endif

  rf_wb_queue #(.WB_DEPTH(WB_DEPTH)) u_wbq (
    .clk          (clk),
    .rst          (rst),
    .i_push       (w_q_push),
    .i_push_entry (w_push_entry),
    .i_pop        (w_op == RF_WRITE),
    .o_head       (w_head),
    .o_full       (w_full),
    .o_empty      (w_empty),
    .o_count      (w_count),
    .i_srch_addr  (w_rd_addr),
    .o_srch_hit   (w_srch_hit),
    .o_srch_data  (w_srch_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_vld   <= 1'b0;
      r_fwd_hit  <= '0;
      r_fwd_data <= '0;
    end else begin
      r_rd_vld <= w_rd_acc;
      for (int p = 0; p < 2; p++) begin
        if (w_rd_acc) begin
          r_fwd_hit[p]  <= w_srch_hit[p];
          r_fwd_data[p] <= w_srch_data[p];
`ifdef RF_R0_ZERO_EN
          // r0 reads reuse the forward path with a constant zero.
          if (w_rd_addr[p] == '0) begin
            r_fwd_hit[p]  <= 1'b1;
            r_fwd_data[p] <= '0;
          end
`endif
        end else begin
          r_fwd_hit[p] <= 1'b0;
        end
      end
    end
  end

  assign rd_data_valid = r_rd_vld;
  assign rd_data_a     = r_fwd_hit[0] ? r_fwd_data[0] : rf_saidaA;
  assign rd_data_b     = r_fwd_hit[1] ? r_fwd_data[1] : rf_saidaB;

  always_comb begin
    rf_RW   = 1'b0;
    rf_regA = rd_addr_a;
    rf_regB = rd_addr_b;
    rf_regC = '0;
    rf_dado = '0;
    if (rst) begin
      rf_regA = '0;
      rf_regB = '0;
    end else if (w_op == RF_WRITE) begin
      rf_RW   = 1'b1;
      rf_regC = w_head.addr;
      rf_dado = w_head.data;
    end
  end
endmodule

// File: tb/tb_rf_access_ctrl.sv
module tb_rf_access_ctrl;
  localparam int DW = 16;
  localparam int AW = 5;
  localparam int WB_DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rd_valid = 1'b0, wb_valid = 1'b0;
  logic [AW-1:0] rd_addr_a = '0, rd_addr_b = '0, wb_addr = '0;
  logic [DW-1:0] wb_data = '0;
  logic rd_ready, rd_data_valid, wb_ready, rf_RW, wb_empty;
  logic [DW-1:0] rd_data_a, rd_data_b, rf_dado, rf_saidaA, rf_saidaB;
  logic [AW-1:0] rf_regA, rf_regB, rf_regC;

  rf_access_ctrl #(.DATA_W(DW), .ADDR_W(AW), .WB_DEPTH(WB_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_valid(rd_data_valid), .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
    .rf_regA(rf_regA), .rf_regB(rf_regB), .rf_regC(rf_regC), .rf_dado(rf_dado),
    .rf_RW(rf_RW), .rf_saidaA(rf_saidaA), .rf_saidaB(rf_saidaB), .wb_empty(wb_empty)
  );

  always #5 clk = ~clk;

  // Register file environment: registered read, write committed at the edge.
  logic [DW-1:0] rf_mem [32] = '{default: '0};
  always @(posedge clk) begin
    if (rf_RW) rf_mem[rf_regC] <= rf_dado;
    else begin
      rf_saidaA <= rf_mem[rf_regA];
      rf_saidaB <= rf_mem[rf_regB];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_err = 0;
  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endfunction

  typedef struct { int due; logic [DW-1:0] a; logic [DW-1:0] b; } exp_t;
  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
  exp_t          sb[$];
  wr_t           pend[$];
  logic [DW-1:0] arch [32];

`ifdef RF_R0_ZERO_EN
  localparam bit R0Z = 1'b1;
`else
  localparam bit R0Z = 1'b0;
`endif

  // Architectural view: a read sees every write accepted up to and including
  // its own cycle. Pending writes reach the file in acceptance order.
  always @(negedge clk) begin
    bit mfull, wr_cyc;
    wr_t e;
    exp_t x;
    if (rst) begin
      pend.delete();
      for (int i = 0; i < 32; i++) arch[i] = rf_mem[i];
    end else begin
      mfull  = (pend.size() == WB_DEPTH);
      wr_cyc = mfull || (!rd_valid && pend.size() != 0);
      chk("rd_ready", rd_ready, !mfull);
      chk("wb_ready", wb_ready, !mfull || wr_cyc);
      chk("wb_empty", wb_empty, pend.size() == 0);
      chk("rf_RW", rf_RW, wr_cyc);
      if (wr_cyc) begin
        e = pend.pop_front();
        chk("rf_regC", rf_regC, e.addr);
        chk("rf_dado", rf_dado, e.data);
      end else if (rd_valid) begin
        chk("rf_regA", rf_regA, rd_addr_a);
        chk("rf_regB", rf_regB, rd_addr_b);
      end
      if (wb_valid && (!mfull || wr_cyc) && !(R0Z && wb_addr == 0)) begin
        arch[wb_addr] = wb_data;
        e.addr = wb_addr; e.data = wb_data;
        pend.push_back(e);
      end
      if (rd_valid && !mfull) begin
        x.due = cyc + 1;
        x.a = arch[rd_addr_a];
        x.b = arch[rd_addr_b];
        sb.push_back(x);
      end
    end
  end

  // Monitor: pops the scoreboard whenever read data is presented.
  always @(negedge clk) begin
    exp_t x;
    if (rst) sb.delete();
    else if (rd_data_valid) begin
      if (sb.size() == 0) chk("rd_spurious", 1, 0);
      else begin
        x = sb.pop_front();
        chk("rd_latency", cyc, x.due);
        chk("rd_data_a", rd_data_a, x.a);
        chk("rd_data_b", rd_data_b, x.b);
      end
    end else if (sb.size() != 0 && sb[0].due <= cyc) begin
      chk("rd_missing", 0, 1);
      void'(sb.pop_front());
    end
  end

  task automatic drv(bit rv, int a, int b, bit wv, int wa, int wd);
    @(posedge clk); #1;
    rd_valid = rv; rd_addr_a = AW'(a); rd_addr_b = AW'(b);
    wb_valid = wv; wb_addr = AW'(wa); wb_data = DW'(wd);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rd_valid = 0; wb_valid = 0;
    #1 rst = 1'b1;
    #1;
    chk("rst_rd_data_valid", rd_data_valid, 0);
    chk("rst_wb_empty", wb_empty, 1);
    chk("rst_rf_RW", rf_RW, 0);
    chk("rst_rf_regC", rf_regC, 0);
    chk("rst_rf_dado", rf_dado, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    int waited;
    #1;
    chk("init_rd_data_valid", rd_data_valid, 0);
    chk("init_wb_empty", wb_empty, 1);
    chk("init_rf_RW", rf_RW, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Read of untouched registers.
    drv(1, 3, 4, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 0);
    // Write then read after commit.
    drv(0, 0, 0, 1, 5, 16'h1234);
    drv(0, 0, 0, 0, 0, 0);
    drv(1, 5, 5, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 0);
    // Four writes to r7 under continuous reads: fill, forced drain.
    for (int i = 1; i <= 4; i++) drv(1, 7, 7, 1, 7, i);
    repeat (4) drv(1, 7, 7, 0, 0, 0);
    repeat (4) drv(0, 0, 0, 0, 0, 0);
    // Same-cycle write and read.
    drv(1, 9, 9, 1, 9, 16'hBEEF);
    drv(0, 0, 0, 0, 0, 0);
    // Fill then reset mid-drain; later reads see committed values only.
    for (int i = 0; i < 4; i++) drv(1, 1, 2, 1, 10 + i, 16'hA000 + i);
    drv(0, 0, 0, 0, 0, 0);
    do_reset();
    drv(1, 10, 11, 0, 0, 0);
    drv(1, 12, 13, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 0);
    // r0 behaviour (hardwired zero when the option is built in).
    drv(0, 0, 0, 1, 0, 16'hFFFF);
    drv(0, 0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 0);

    // Randomised traffic, mostly over a small address window for forwarding.
    for (int n = 0; n < 3000; n++) begin
      int a, b, wa;
      a  = ($urandom_range(3) == 0) ? $urandom_range(31) : $urandom_range(7);
      b  = ($urandom_range(3) == 0) ? $urandom_range(31) : $urandom_range(7);
      wa = ($urandom_range(3) == 0) ? $urandom_range(31) : $urandom_range(7);
      drv($urandom_range(99) < 60, a, b, $urandom_range(99) < 55, wa, $urandom_range(16'hFFFF));
      if (n % 750 == 749) do_reset();
    end

    // Drain and compare the file with the architectural state.
    drv(0, 0, 0, 0, 0, 0);
    waited = 0;
    while (!wb_empty && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    chk("drain_timeout", waited < 20, 1);
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 32; i++) chk($sformatf("final_r%0d", i), rf_mem[i], arch[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
